// File: rtl/fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls in, instruction-memory handshake
// and IF/ID payload out.
interface fetch_if;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] next_instruct;
    logic [31:0] current_instruct;
    logic        fetch_valid;
    logic        flush;

    modport master (
        input  pc_write, branch_taken, branch_target, jump, jump_target,
        input  imem_ready, imem_rdata,
        output imem_req, imem_addr, pc, next_instruct, current_instruct,
        output fetch_valid, flush
    );

    modport slave (
        output pc_write, branch_taken, branch_target, jump, jump_target,
        output imem_ready, imem_rdata,
        input  imem_req, imem_addr, pc, next_instruct, current_instruct,
        input  fetch_valid, flush
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory, buffers a
// word across hazard stalls and applies branch/jump redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic clock,
    input  logic clear,
    fetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] next_q, next_d;
    logic [31:0] hold_q, hold_d;
    logic        fv_q, fv_d;
    logic        flush_q, flush_d;
    logic [31:0] pc_plus;

    assign pc_plus = pc_q + PC_STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cur_d   = cur_q;
        next_d  = next_q;
        hold_d  = hold_q;
        fv_d    = 1'b0;
        flush_d = 1'b0;
        // Redirects override stalls and discard any word returned this cycle.
        if (bus.branch_taken) begin
            pc_d    = bus.branch_target;
            flush_d = 1'b1;
            state_d = REQ;
        end else if (bus.jump) begin
            pc_d    = bus.jump_target;
            flush_d = 1'b1;
            state_d = REQ;
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (bus.imem_ready) begin
                        if (bus.pc_write) begin
                            cur_d  = bus.imem_rdata;
                            next_d = pc_plus;
                            fv_d   = 1'b1;
                            pc_d   = pc_plus;
                        end else begin
                            hold_d  = bus.imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.pc_write) begin
                        cur_d   = hold_q;
                        next_d  = pc_plus;
                        fv_d    = 1'b1;
                        pc_d    = pc_plus;
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cur_q   <= 32'h0;
            next_q  <= 32'h0;
            hold_q  <= 32'h0;
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cur_q   <= cur_d;
            next_q  <= next_d;
            hold_q  <= hold_d;
            fv_q    <= fv_d;
            flush_q <= flush_d;
        end
    end

    assign bus.imem_req         = (state_q == REQ);
    assign bus.imem_addr        = pc_q;
    assign bus.pc               = pc_q;
    assign bus.current_instruct = cur_q;
    assign bus.next_instruct    = next_q;
    assign bus.fetch_valid      = fv_q;
    assign bus.flush            = flush_q;

endmodule
